// File: rtl/bootrom_copy_ctrl.sv
// Boot ROM to RAM copier holding the CPU in reset until done; option BOOTROM_COPY_CHECKSUM_EN.
// Latency: 3 cycles per 16-bit word (READ, WAIT, WRITE) with the RAM always ready.
// Backpressure: WRITE holds we/addr/data stable until I_ram_ready is sampled high.
module bootrom_copy_ctrl #(
    parameter int                ROM_AW       = 8,
    parameter int                RAM_AW       = 16,
    parameter int                BYTE_COUNT   = 256,
    parameter logic [RAM_AW-1:0] DEST_BASE    = '0,
    parameter logic [15:0]       EXPECTED_SUM = 16'h0000
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_start,
    output logic              O_rom_enable,
    output logic [ROM_AW-1:0] O_rom_addr,
    input  logic [15:0]       I_rom_data,
    output logic              O_ram_we,
    output logic [RAM_AW-1:0] O_ram_addr,
    output logic [15:0]       O_ram_data,
    input  logic              I_ram_ready,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_cpu_reset,
    output logic [15:0]       O_checksum,
    output logic              O_checksum_ok
);

    // One extra pointer bit lets a full 2^ROM_AW image finish without wrapping.
    localparam int            PW       = ROM_AW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(BYTE_COUNT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          accept;
    logic          last_word;
    logic          release_ok;

    assign ptr_next  = ptr + PW'(2);
    assign accept    = (state == S_WRITE) && I_ram_ready;
    assign last_word = (ptr == LAST_PTR);

`ifdef BOOTROM_COPY_CHECKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] sum_next;
    logic        sum_ok_q;

    assign sum_next   = sum_q + O_ram_data;
    assign release_ok = (sum_next == EXPECTED_SUM);

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sum_q    <= '0;
            sum_ok_q <= 1'b0;
        end else if ((state == S_IDLE) && I_start) begin
            sum_q    <= '0;
            sum_ok_q <= 1'b0;
        end else if (accept) begin
            sum_q <= sum_next;
            if (last_word) begin
                sum_ok_q <= release_ok;
            end
        end
    end

    assign O_checksum    = sum_q;
    assign O_checksum_ok = sum_ok_q;
`else
    logic unused_expected_sum;

    assign unused_expected_sum = ^EXPECTED_SUM;
    assign release_ok          = 1'b1;
    assign O_checksum          = '0;
    assign O_checksum_ok       = 1'b1;
`endif

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            O_rom_enable <= 1'b0;
            O_rom_addr   <= '0;
            O_ram_we     <= 1'b0;
            O_ram_addr   <= '0;
            O_ram_data   <= '0;
            O_busy       <= 1'b0;
            O_done       <= 1'b0;
            O_cpu_reset  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_start) begin
                        state        <= S_READ;
                        ptr          <= '0;
                        O_busy       <= 1'b1;
                        O_rom_enable <= 1'b1;
                        O_rom_addr   <= '0;
                    end
                end
                S_READ: begin
                    O_rom_enable <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // ROM word is valid only in this cycle; it lands in the write-data register.
                    O_ram_data <= I_rom_data;
                    O_ram_addr <= DEST_BASE + RAM_AW'(ptr);
                    O_ram_we   <= 1'b1;
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    if (I_ram_ready) begin
                        O_ram_we <= 1'b0;
                        if (last_word) begin
                            state       <= S_DONE;
                            O_busy      <= 1'b0;
                            O_done      <= 1'b1;
                            O_cpu_reset <= !release_ok;
                        end else begin
                            ptr          <= ptr_next;
                            O_rom_enable <= 1'b1;
                            O_rom_addr   <= ptr_next[ROM_AW-1:0];
                            state        <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_copy_ctrl.sv
// Scoreboard bench for bootrom_copy_ctrl: expected ROM reads and RAM writes are queued per copy.
module tb_bootrom_copy_ctrl;

`ifdef BOOTROM_COPY_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        rom_enable;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_ready;
    logic        busy;
    logic        done;
    logic        cpu_reset;
    logic [15:0] checksum;
    logic        checksum_ok;

    bootrom_copy_ctrl #(
        .ROM_AW(8), .RAM_AW(16), .BYTE_COUNT(256),
        .DEST_BASE(16'h1000), .EXPECTED_SUM(16'h8080)
    ) dut (
        .I_clk(clk), .I_reset_n(reset_n), .I_start(start),
        .O_rom_enable(rom_enable), .O_rom_addr(rom_addr), .I_rom_data(rom_data),
        .O_ram_we(ram_we), .O_ram_addr(ram_addr), .O_ram_data(ram_data),
        .I_ram_ready(ram_ready), .O_busy(busy), .O_done(done),
        .O_cpu_reset(cpu_reset), .O_checksum(checksum), .O_checksum_ok(checksum_ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM model: word appears the cycle after enable.
    logic [7:0]  rom [256];
    logic [15:0] rom_q;
    always @(posedge clk) if (rom_enable) rom_q <= {rom[8'(rom_addr + 8'd1)], rom[rom_addr]};
    assign rom_data = rom_q;

    logic [7:0]  exp_rom  [$];
    logic [15:0] exp_addr [$];
    logic [15:0] exp_data [$];
    logic [15:0] ram [logic [15:0]];

    int checks = 0;
    int errors = 0;
    int acc_count = 0;
    int we_cycles = 0;
    int lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] ra;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rom_enable) begin
                    if (exp_rom.size() == 0) check("rom_read_unexpected", {24'h0, rom_addr}, 32'hFFFF_FFFF);
                    else begin
                        ra = exp_rom.pop_front();
                        check("rom_addr_seq", {24'h0, rom_addr}, {24'h0, ra});
                    end
                end
                if (ram_we) begin
                    we_cycles++;
                    if (exp_addr.size() == 0) check("ram_write_unexpected", {16'h0, ram_addr}, 32'hFFFF_FFFF);
                    else begin
                        check("ram_write", {ram_addr, ram_data}, {exp_addr[0], exp_data[0]});
                        if (ram_ready) begin
                            ram[ram_addr] = ram_data;
                            void'(exp_addr.pop_front());
                            void'(exp_data.pop_front());
                            acc_count++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic push_copy();
        for (int i = 0; i < 128; i++) begin
            exp_rom.push_back(8'(2 * i));
            exp_addr.push_back(16'h1000 + 16'(2 * i));
            exp_data.push_back({rom[2 * i + 1], rom[2 * i]});
        end
    endtask

    task automatic run_copy(input bit stall, input bit pulse_mid, output int latency);
        int t0;
        int stall_left;
        bit stalled;
        bit pulsed;
        t0 = -1; latency = -1; stall_left = 0; stalled = 0; pulsed = 0;
        acc_count = 0; we_cycles = 0;
        push_copy();
        @(posedge clk); #1 start = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (stall && !stalled && ram_we && acc_count == 3) begin
                ram_ready = 1'b0; stall_left = 5; stalled = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ram_ready = 1'b1;
            end
            if (pulse_mid && !pulsed && acc_count == 10) begin
                start = 1'b1; pulsed = 1;
            end
            @(negedge clk);
            if (t0 < 0 && rom_enable) t0 = cyc;
            if (done) begin
                latency = cyc - t0;
                break;
            end
        end
        check("copy_done_reached", {31'h0, done}, 32'h1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ram.delete();
    endtask

    task automatic reset_mid_copy();
        acc_count = 0;
        push_copy();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 1000 && acc_count < 40; n++) @(negedge clk);
        check("reached_word40", acc_count, 40);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {rom_enable, ram_we, busy, done, cpu_reset}, 5'b00001);
        check("rst_mid_addr", {rom_addr, ram_addr}, 24'h0);
        check("rst_mid_data", ram_data, 16'h0);
        exp_rom.delete(); exp_addr.delete(); exp_data.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {cpu_reset, busy, done, rom_enable}, 4'b1000);
    endtask

    task automatic main_seq();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        repeat (2) @(negedge clk);
        check("rst_ctrl", {rom_enable, ram_we, busy, done, cpu_reset}, 5'b00001);
        check("rst_addr", {rom_addr, ram_addr}, 24'h0);
        check("rst_data", ram_data, 16'h0);
        check("rst_cksum", {checksum_ok, checksum}, {~CK, 16'h0});
        @(posedge clk); #1 reset_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check("idle_no_start", {cpu_reset, busy, done, rom_enable, ram_we}, 5'b10000);
        end

        run_copy(1'b0, 1'b0, lat);
        check("latency_nostall", lat, 384);
        check("done_ctrl_a", {busy, done, cpu_reset}, {2'b01, CK});
        check("we_cycles_a", we_cycles, 128);
        check("ram_first", ram[16'h1000], 16'h0100);
        check("ram_last", ram[16'h10FE], 16'hFFFE);
        check("queue_drained_a", exp_addr.size(), 0);
        // Sum of the byte-ramp image: 0x3F80, which mismatches EXPECTED_SUM.
        check("cksum_ramp", {checksum_ok, checksum}, CK ? {1'b0, 16'h3F80} : {1'b1, 16'h0000});

        pulse_reset();
        run_copy(1'b1, 1'b1, lat);
        check("latency_stall", lat, 389);
        check("we_cycles_stall", we_cycles, 133);
        check("ram_word3", ram[16'h1006], 16'h0706);
        check("done_ctrl_b", {busy, done, cpu_reset}, {2'b01, CK});

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("start_in_done", {busy, done, rom_enable, ram_we, cpu_reset}, {4'b0100, CK});

        pulse_reset();
        reset_mid_copy();
        run_copy(1'b0, 1'b0, lat);
        check("latency_restart", lat, 384);
        check("ram_first_restart", ram[16'h1000], 16'h0100);
        check("queue_drained_c", exp_addr.size(), 0);

`ifdef BOOTROM_COPY_CHECKSUM_EN
        pulse_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'h01;
        run_copy(1'b0, 1'b0, lat);
        check("cksum_ones", checksum, 16'h8080);
        check("cksum_ok_ones", {checksum_ok, cpu_reset}, 2'b10);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        ram_ready = 1'b1;
        fork
            monitor();
            main_seq();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
